// File: rtl/wb_regfile_fwd_if.sv
// Purpose : bundles the ID-stage read ports, the EX/MEM/WB forwarding taps and
//           the writeback channel that connect the pipeline to wb_regfile_fwd.
// Ports   : master - pipeline side (drives addresses, stage info, writeback;
//                    receives read data and stall)
//           slave  - register file side (the reverse)
interface wb_regfile_fwd_if #(
  parameter int DATA_W = 32
);
  // ID-stage read ports
  logic [4:0]        rR1_i;
  logic [4:0]        rR2_i;
  logic              rs1_used_i;
  logic              rs2_used_i;
  logic [DATA_W-1:0] rD1_o;
  logic [DATA_W-1:0] rD2_o;
  // EX stage
  logic [4:0]        ex_wR_i;
  logic              ex_rf_we_i;
  logic              ex_is_load_i;
  logic [DATA_W-1:0] ex_wD_i;
  // MEM stage
  logic [4:0]        mem_wR_i;
  logic              mem_rf_we_i;
  logic [DATA_W-1:0] mem_wD_i;
  // WB stage (output of the MEM/WB register)
  logic [4:0]        wb_wR_i;
  logic              wb_rf_we_i;
  logic [DATA_W-1:0] wb_wD_i;
  // Hazard
  logic              stall_o;

  modport master (
    output rR1_i, rR2_i, rs1_used_i, rs2_used_i,
    output ex_wR_i, ex_rf_we_i, ex_is_load_i, ex_wD_i,
    output mem_wR_i, mem_rf_we_i, mem_wD_i,
    output wb_wR_i, wb_rf_we_i, wb_wD_i,
    input  rD1_o, rD2_o, stall_o
  );

  modport slave (
    input  rR1_i, rR2_i, rs1_used_i, rs2_used_i,
    input  ex_wR_i, ex_rf_we_i, ex_is_load_i, ex_wD_i,
    input  mem_wR_i, mem_rf_we_i, mem_wD_i,
    input  wb_wR_i, wb_rf_we_i, wb_wD_i,
    output rD1_o, rD2_o, stall_o
  );
endinterface

// File: rtl/wb_regfile_fwd.sv
// Purpose : architectural register file at the end of the writeback path.
//           Commits WB writes, serves two combinational ID read ports with
//           EX > MEM > WB > array forwarding, and flags load-use hazards.
// Ports   : clk_i   - clock, rising edge
//           rst_n_i - asynchronous active-low reset; clears the array and
//                     forces rD1_o/rD2_o/stall_o to 0 while asserted
//           bus     - wb_regfile_fwd_if.slave (read ports, stage taps, stall)
// REG_N is fixed at 32 because register addresses are 5 bits wide.
module wb_regfile_fwd #(
  parameter int                DATA_W    = 32,
  parameter int                REG_N     = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  wb_regfile_fwd_if.slave     bus
);

  logic [DATA_W-1:0] regs_reg [REG_N];

  // Every register is cleared by the asynchronous reset, so the array is
  // built from flops rather than a RAM macro. Writes to x0 are discarded.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_N; i++) begin
        regs_reg[i] <= RESET_VAL;
      end
    end else if (bus.wb_rf_we_i && (bus.wb_wR_i != 5'd0)) begin
      regs_reg[bus.wb_wR_i] <= bus.wb_wD_i;
    end
  end

  // Per-port read addresses and "operand consumed" flags, indexed by port.
  logic [4:0] port_addr [2];
  logic       port_used [2];
  assign port_addr[0] = bus.rR1_i;
  assign port_addr[1] = bus.rR2_i;
  assign port_used[0] = bus.rs1_used_i;
  assign port_used[1] = bus.rs2_used_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rd_data;
      logic              hazard;

      // Youngest matching stage wins. A load in EX has no data yet, so it is
      // skipped here and covered by the stall instead.
      always_comb begin
        rd_data = regs_reg[port_addr[gi]];
        if (port_addr[gi] == 5'd0) begin
          rd_data = '0;
        end else if (bus.ex_rf_we_i && (bus.ex_wR_i == port_addr[gi]) && !bus.ex_is_load_i) begin
          rd_data = bus.ex_wD_i;
        end else if (bus.mem_rf_we_i && (bus.mem_wR_i == port_addr[gi])) begin
          rd_data = bus.mem_wD_i;
        end else if (bus.wb_rf_we_i && (bus.wb_wR_i == port_addr[gi])) begin
          rd_data = bus.wb_wD_i;
        end
      end

      assign hazard = port_used[gi] && (bus.ex_wR_i == port_addr[gi]);
    end
  endgenerate

  logic stall_raw;
  assign stall_raw = bus.ex_rf_we_i && bus.ex_is_load_i && (bus.ex_wR_i != 5'd0) &&
                     (g_port[0].hazard || g_port[1].hazard);

  // Outputs are held quiet during reset regardless of the stage inputs.
  assign bus.rD1_o   = rst_n_i ? g_port[0].rd_data : '0;
  assign bus.rD2_o   = rst_n_i ? g_port[1].rd_data : '0;
  assign bus.stall_o = rst_n_i && stall_raw;

endmodule

// File: tb/tb_wb_regfile_fwd.sv
module tb_wb_regfile_fwd;

  logic clk_i;
  logic rst_n_i;

  wb_regfile_fwd_if #(.DATA_W(32)) bus ();

  wb_regfile_fwd #(.DATA_W(32), .REG_N(32), .RESET_VAL(32'h0)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int          tests;
  int          failed;
  logic [31:0] exp_q [$];
  logic [31:0] got;
  logic [31:0] exp;
  logic [31:0] model [32];

  task automatic idle_inputs();
    bus.rR1_i = 5'd0;       bus.rR2_i = 5'd0;
    bus.rs1_used_i = 1'b0;  bus.rs2_used_i = 1'b0;
    bus.ex_wR_i = 5'd0;     bus.ex_rf_we_i = 1'b0;
    bus.ex_is_load_i = 1'b0; bus.ex_wD_i = 32'h0;
    bus.mem_wR_i = 5'd0;    bus.mem_rf_we_i = 1'b0;  bus.mem_wD_i = 32'h0;
    bus.wb_wR_i = 5'd0;     bus.wb_rf_we_i = 1'b0;   bus.wb_wD_i = 32'h0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    idle_inputs();
    #12;
    // Forwarding and a raw hazard are active, but reset must mask all outputs.
    bus.ex_rf_we_i = 1'b1; bus.ex_wR_i = 5'd1; bus.ex_wD_i = 32'hFFFF_0001;
    bus.rR1_i = 5'd1; bus.rR2_i = 5'd1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL reset_rd1 got=%h exp=%h", got, exp); end
    else $display("[TB] reset_rd1 got=%h", got);
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL reset_rd2 got=%h exp=%h", got, exp); end
    else $display("[TB] reset_rd2 got=%h", got);
    bus.ex_is_load_i = 1'b1; bus.rs1_used_i = 1'b1;
    exp_q.push_back(32'h0);
    #1;
    tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL reset_stall got=%h exp=%h", got, exp); end
    else $display("[TB] reset_stall got=%h", got);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle_inputs();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      bus.rR1_i = 5'(i); bus.rR2_i = 5'(31 - i);
      exp_q.push_back(model[i]); exp_q.push_back(model[31 - i]); exp_q.push_back(32'h0);
      #1;
      tests++; got = bus.rD1_o; exp = exp_q.pop_front();
      if (got !== exp) begin failed++; $display("FAIL reset_read_rd1 r%0d got=%h exp=%h", i, got, exp); end
      else $display("[TB] reset_read_rd1 r%0d got=%h", i, got);
      tests++; got = bus.rD2_o; exp = exp_q.pop_front();
      if (got !== exp) begin failed++; $display("FAIL reset_read_rd2 r%0d got=%h exp=%h", 31 - i, got, exp); end
      else $display("[TB] reset_read_rd2 r%0d got=%h", 31 - i, got);
      tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
      if (got !== exp) begin failed++; $display("FAIL reset_read_stall got=%h exp=%h", got, exp); end
    end
  endtask

  task automatic test_wb_bypass();
    @(negedge clk_i);
    idle_inputs();
    bus.wb_rf_we_i = 1'b1; bus.wb_wR_i = 5'd5; bus.wb_wD_i = 32'hDEAD_BEEF;
    bus.rR1_i = 5'd5;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL wb_bypass got=%h exp=%h", got, exp); end
    else $display("[TB] wb_bypass got=%h", got);
    model[5] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    idle_inputs();
    bus.rR1_i = 5'd5;
    exp_q.push_back(model[5]);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL wb_commit got=%h exp=%h", got, exp); end
    else $display("[TB] wb_commit got=%h", got);
  endtask

  task automatic test_zero_reg();
    @(negedge clk_i);
    idle_inputs();
    bus.wb_rf_we_i = 1'b1; bus.wb_wR_i = 5'd0; bus.wb_wD_i = 32'h1234;
    bus.rR1_i = 5'd0; bus.rR2_i = 5'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL zero_wb_rd1 got=%h exp=%h", got, exp); end
    else $display("[TB] zero_wb_rd1 got=%h", got);
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL zero_wb_rd2 got=%h exp=%h", got, exp); end
    else $display("[TB] zero_wb_rd2 got=%h", got);
    @(negedge clk_i);
    idle_inputs();
    bus.ex_rf_we_i = 1'b1; bus.ex_wR_i = 5'd0; bus.ex_wD_i = 32'h99;
    bus.mem_rf_we_i = 1'b1; bus.mem_wR_i = 5'd0; bus.mem_wD_i = 32'h98;
    bus.rR1_i = 5'd0; bus.rR2_i = 5'd0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL zero_ex_rd1 got=%h exp=%h", got, exp); end
    else $display("[TB] zero_ex_rd1 got=%h", got);
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL zero_ex_rd2 got=%h exp=%h", got, exp); end
    else $display("[TB] zero_ex_rd2 got=%h", got);
    // A load targeting x0 is never a hazard.
    bus.ex_is_load_i = 1'b1; bus.rs1_used_i = 1'b1; bus.rs2_used_i = 1'b1;
    exp_q.push_back(32'h0);
    #1;
    tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL zero_load_stall got=%h exp=%h", got, exp); end
    else $display("[TB] zero_load_stall got=%h", got);
  endtask

  task automatic test_priority();
    @(negedge clk_i);
    idle_inputs();
    bus.ex_rf_we_i = 1'b1;  bus.ex_wR_i = 5'd3;  bus.ex_wD_i = 32'hA;
    bus.mem_rf_we_i = 1'b1; bus.mem_wR_i = 5'd3; bus.mem_wD_i = 32'hB;
    bus.wb_rf_we_i = 1'b1;  bus.wb_wR_i = 5'd3;  bus.wb_wD_i = 32'hC;
    bus.rR2_i = 5'd3;
    exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
    #1;
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL prio_ex got=%h exp=%h", got, exp); end
    else $display("[TB] prio_ex got=%h", got);
    bus.ex_rf_we_i = 1'b0;
    #1;
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL prio_mem got=%h exp=%h", got, exp); end
    else $display("[TB] prio_mem got=%h", got);
    bus.mem_rf_we_i = 1'b0;
    #1;
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL prio_wb got=%h exp=%h", got, exp); end
    else $display("[TB] prio_wb got=%h", got);
    model[3] = 32'hC;
    // Matching addresses with every enable low must not forward.
    @(negedge clk_i);
    idle_inputs();
    bus.ex_wR_i = 5'd3;  bus.ex_wD_i = 32'h1;
    bus.mem_wR_i = 5'd3; bus.mem_wD_i = 32'h2;
    bus.wb_wR_i = 5'd3;  bus.wb_wD_i = 32'h3;
    bus.rR2_i = 5'd3;
    exp_q.push_back(model[3]);
    #1;
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL prio_no_we got=%h exp=%h", got, exp); end
    else $display("[TB] prio_no_we got=%h", got);
  endtask

  task automatic test_load_use();
    @(negedge clk_i);
    idle_inputs();
    bus.ex_rf_we_i = 1'b1; bus.ex_is_load_i = 1'b1; bus.ex_wR_i = 5'd7; bus.ex_wD_i = 32'hBAD;
    bus.rR1_i = 5'd7; bus.rs1_used_i = 1'b1;
    bus.rR2_i = 5'd5; bus.rs2_used_i = 1'b1;
    exp_q.push_back(32'h1); exp_q.push_back(model[5]);
    #1;
    tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL load_use_stall got=%h exp=%h", got, exp); end
    else $display("[TB] load_use_stall got=%h", got);
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL load_use_other_port got=%h exp=%h", got, exp); end
    else $display("[TB] load_use_other_port got=%h", got);
    // Load moves to MEM, a bubble occupies EX.
    @(negedge clk_i);
    idle_inputs();
    bus.mem_rf_we_i = 1'b1; bus.mem_wR_i = 5'd7; bus.mem_wD_i = 32'h55;
    bus.rR1_i = 5'd7; bus.rs1_used_i = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h55);
    #1;
    tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL load_use_release got=%h exp=%h", got, exp); end
    else $display("[TB] load_use_release got=%h", got);
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL load_use_fwd got=%h exp=%h", got, exp); end
    else $display("[TB] load_use_fwd got=%h", got);
    // Hazard seen through port 2 alone.
    @(negedge clk_i);
    idle_inputs();
    bus.ex_rf_we_i = 1'b1; bus.ex_is_load_i = 1'b1; bus.ex_wR_i = 5'd9;
    bus.rR2_i = 5'd9; bus.rs2_used_i = 1'b1;
    exp_q.push_back(32'h1);
    #1;
    tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL load_use_port2 got=%h exp=%h", got, exp); end
    else $display("[TB] load_use_port2 got=%h", got);
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      idle_inputs();
      bus.wb_rf_we_i = 1'b1; bus.wb_wR_i = 5'(i); bus.wb_wD_i = 32'h0101_0101 * i + 32'h100;
      bus.rR1_i = 5'(i - 1); bus.rR2_i = 5'(i);
      exp_q.push_back((i == 1) ? 32'h0 : model[i - 1]);
      exp_q.push_back(32'h0101_0101 * i + 32'h100);
      #1;
      tests++; got = bus.rD1_o; exp = exp_q.pop_front();
      if (got !== exp) begin failed++; $display("FAIL b2b_prev r%0d got=%h exp=%h", i - 1, got, exp); end
      else $display("[TB] b2b_prev r%0d got=%h", i - 1, got);
      tests++; got = bus.rD2_o; exp = exp_q.pop_front();
      if (got !== exp) begin failed++; $display("FAIL b2b_bypass r%0d got=%h exp=%h", i, got, exp); end
      else $display("[TB] b2b_bypass r%0d got=%h", i, got);
      model[i] = 32'h0101_0101 * i + 32'h100;
    end
    @(negedge clk_i);
    idle_inputs();
    bus.rR1_i = 5'd8; bus.rR2_i = 5'd3;
    exp_q.push_back(model[8]); exp_q.push_back(model[3]);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL b2b_last got=%h exp=%h", got, exp); end
    else $display("[TB] b2b_last got=%h", got);
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL b2b_r3 got=%h exp=%h", got, exp); end
    else $display("[TB] b2b_r3 got=%h", got);
  endtask

  task automatic test_no_use_and_reset();
    @(negedge clk_i);
    idle_inputs();
    bus.wb_rf_we_i = 1'b1; bus.wb_wR_i = 5'd7; bus.wb_wD_i = 32'h77;
    model[7] = 32'h77;
    @(negedge clk_i);
    idle_inputs();
    bus.ex_rf_we_i = 1'b1; bus.ex_is_load_i = 1'b1; bus.ex_wR_i = 5'd7; bus.ex_wD_i = 32'hBAD;
    bus.rR1_i = 5'd7; bus.rR2_i = 5'd7;
    exp_q.push_back(32'h0); exp_q.push_back(model[7]);
    #1;
    tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL unused_no_stall got=%h exp=%h", got, exp); end
    else $display("[TB] unused_no_stall got=%h", got);
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL load_not_forwarded got=%h exp=%h", got, exp); end
    else $display("[TB] load_not_forwarded got=%h", got);
    // Mid-cycle reset with a live hazard: everything drops at once.
    bus.rs1_used_i = 1'b1;
    rst_n_i = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    #1;
    tests++; got = {31'h0, bus.stall_o}; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL midreset_stall got=%h exp=%h", got, exp); end
    else $display("[TB] midreset_stall got=%h", got);
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL midreset_rd1 got=%h exp=%h", got, exp); end
    else $display("[TB] midreset_rd1 got=%h", got);
    // A WB write across an edge held in reset must be ignored.
    @(negedge clk_i);
    idle_inputs();
    bus.wb_rf_we_i = 1'b1; bus.wb_wR_i = 5'd10; bus.wb_wD_i = 32'hEE;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    idle_inputs();
    bus.wb_rf_we_i = 1'b1; bus.wb_wR_i = 5'd9; bus.wb_wD_i = 32'hAB;
    bus.rR1_i = 5'd7; bus.rR2_i = 5'd10;
    exp_q.push_back(model[7]); exp_q.push_back(model[10]);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL reset_cleared_r7 got=%h exp=%h", got, exp); end
    else $display("[TB] reset_cleared_r7 got=%h", got);
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL reset_blocked_r10 got=%h exp=%h", got, exp); end
    else $display("[TB] reset_blocked_r10 got=%h", got);
    model[9] = 32'hAB;
    @(negedge clk_i);
    idle_inputs();
    bus.rR1_i = 5'd9; bus.rR2_i = 5'd1;
    exp_q.push_back(model[9]); exp_q.push_back(model[1]);
    #1;
    tests++; got = bus.rD1_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL first_write_after_reset got=%h exp=%h", got, exp); end
    else $display("[TB] first_write_after_reset got=%h", got);
    tests++; got = bus.rD2_o; exp = exp_q.pop_front();
    if (got !== exp) begin failed++; $display("FAIL reset_cleared_r1 got=%h exp=%h", got, exp); end
    else $display("[TB] reset_cleared_r1 got=%h", got);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_wb_bypass();
    test_zero_reg();
    test_priority();
    test_load_use();
    test_back_to_back();
    test_no_use_and_reset();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
